round_engine: RTL and testbench

ROUND_ENGINE -- requirements
Module: round_engine

---
 rtl/threefish_pkg.sv | 36 +++
 rtl/threefish_mix.sv | 21 ++
 rtl/round_engine.sv | 162 ++++++++++++++++
 tb/tb_round_engine.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/threefish_pkg.sv
// threefish_pkg: constants and types shared by the Threefish-512 round engine.
//   C240        key-schedule parity constant
//   RotTable    MIX rotation amounts, indexed [round mod 8][pair]
//   PermTable   word permutation applied after each round: new[i] = old[PermTable[i]]
//   NumRounds   MIX rounds per block (72)
//   NumSubkeys  subkeys injected per block (19)
//   engineState_e  round_engine FSM states
package threefish_pkg;

  localparam logic [63:0] C240       = 64'h1BD1_1BDA_A9FC_1A22;
  localparam int unsigned NumRounds  = 72;
  localparam int unsigned NumSubkeys = 19;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFinal,
    StDone
  } engineState_e;

  localparam logic [5:0] RotTable [8][4] = '{
    '{6'd46, 6'd36, 6'd19, 6'd37},
    '{6'd33, 6'd27, 6'd14, 6'd42},
    '{6'd17, 6'd49, 6'd36, 6'd39},
    '{6'd44, 6'd9,  6'd54, 6'd56},
    '{6'd39, 6'd30, 6'd34, 6'd24},
    '{6'd13, 6'd50, 6'd10, 6'd17},
    '{6'd25, 6'd29, 6'd39, 6'd43},
    '{6'd8,  6'd35, 6'd56, 6'd22}
  };

  localparam logic [2:0] PermTable [8] = '{
    3'd2, 3'd1, 3'd4, 3'd7, 3'd6, 3'd5, 3'd0, 3'd3
  };

endpackage

// File: rtl/threefish_mix.sv
// threefish_mix: combinational Threefish MIX function on one word pair.
//   inX0, inX1  input words
//   inRot       left-rotation amount for the second word
//   outY0       inX0 + inX1 (mod 2^64)
//   outY1       rotl(inX1, inRot) ^ outY0
module threefish_mix (
  input  logic [63:0] inX0,
  input  logic [63:0] inX1,
  input  logic [5:0]  inRot,
  output logic [63:0] outY0,
  output logic [63:0] outY1
);

  logic [63:0] rotated;

  // A zero rotation shifts right by 64, which yields 0 and leaves inX1 intact.
  assign rotated = (inX1 << inRot) | (inX1 >> (7'd64 - {1'b0, inRot}));
  assign outY0   = inX0 + inX1;
  assign outY1   = rotated ^ outY0;

endmodule

// File: rtl/round_engine.sv
// round_engine: Threefish-512 encryption sequencer that drives an external round register.
//   inClk/inRstN  clock, asynchronous active-low reset
//   inStart       start request, honoured only in IDLE
//   inAbort       (only when ROUNDENG_ABORT_EN is defined) abandon the running operation
//   inKey         k0..k7, word i in bits [64i+63:64i]
//   inTweak       t0 in [63:0], t1 in [127:64]
//   inState       current round register contents
//   outWr/outBlock  write strobe and next state for the round register (block is 0 when idle)
//   outBusy       high in RUN and FINAL
//   outDone       one-cycle pulse once the ciphertext sits in the round register
// Build option: define ROUNDENG_ABORT_EN to add the inAbort port.
module round_engine
  import threefish_pkg::*;
(
  input  logic         inClk,
  input  logic         inRstN,
  input  logic         inStart,
`ifdef ROUNDENG_ABORT_EN
  input  logic         inAbort,
`endif
  input  logic [511:0] inKey,
  input  logic [127:0] inTweak,
  input  logic [511:0] inState,
  output logic         outWr,
  output logic [511:0] outBlock,
  output logic         outBusy,
  output logic         outDone
);

  engineState_e stateQ, stateD;
  logic [6:0]   roundQ, roundD;
  logic [8:0][63:0] keyQ;
  logic [2:0][63:0] tweakQ;
  logic         startAccept;

  logic [63:0]      keyParity;
  logic [4:0]       subIdx;
  logic [7:0][63:0] subkey;
  logic [7:0][63:0] mixIn;
  logic [7:0][63:0] mixOut;
  logic [511:0]     roundOut;
  logic [511:0]     finalOut;
  logic [3:0][5:0]  rotAmt;

  always_comb begin
    keyParity = C240;
    for (int i = 0; i < 8; i++) begin
      keyParity = keyParity ^ inKey[64*i +: 64];
    end
  end

  // Subkey index: round/4 while running, the last subkey (18) in FINAL.
  assign subIdx = (stateQ == StFinal) ? 5'(NumSubkeys - 1) : roundQ[6:2];

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      subkey[i] = keyQ[4'((32'(subIdx) + i) % 9)];
    end
    subkey[5] = subkey[5] + tweakQ[2'(32'(subIdx) % 3)];
    subkey[6] = subkey[6] + tweakQ[2'((32'(subIdx) + 1) % 3)];
    subkey[7] = subkey[7] + 64'(subIdx);
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      mixIn[i]               = inState[64*i +: 64];
      finalOut[64*i +: 64]   = inState[64*i +: 64] + subkey[i];
      if (roundQ[1:0] == 2'd0) begin
        mixIn[i] = mixIn[i] + subkey[i];
      end
    end
  end

  for (genvar j = 0; j < 4; j++) begin : gMix
    assign rotAmt[j] = RotTable[roundQ[2:0]][j];

    threefish_mix uMix (
      .inX0  (mixIn[2*j]),
      .inX1  (mixIn[2*j+1]),
      .inRot (rotAmt[j]),
      .outY0 (mixOut[2*j]),
      .outY1 (mixOut[2*j+1])
    );
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      roundOut[64*i +: 64] = mixOut[PermTable[i]];
    end
  end

  always_comb begin
    stateD      = stateQ;
    roundD      = roundQ;
    outWr       = 1'b0;
    outBlock    = '0;
    outBusy     = 1'b0;
    outDone     = 1'b0;
    startAccept = 1'b0;

    unique case (stateQ)
      StIdle: begin
        if (inStart) begin
          startAccept = 1'b1;
          stateD      = StRun;
          roundD      = '0;
        end
      end
      StRun: begin
        outBusy  = 1'b1;
        outWr    = 1'b1;
        outBlock = roundOut;
        if (roundQ == 7'(NumRounds - 1)) begin
          stateD = StFinal;
        end else begin
          roundD = roundQ + 7'd1;
        end
      end
      StFinal: begin
        outBusy  = 1'b1;
        outWr    = 1'b1;
        outBlock = finalOut;
        stateD   = StDone;
      end
      StDone: begin
        outDone = 1'b1;
        stateD  = StIdle;
        roundD  = '0;
      end
      default: stateD = StIdle;
    endcase

`ifdef ROUNDENG_ABORT_EN
    // Abort wins over round progress: suppress this edge's write and drop to IDLE.
    if (inAbort && (stateQ == StRun || stateQ == StFinal)) begin
      stateD   = StIdle;
      roundD   = '0;
      outWr    = 1'b0;
      outBlock = '0;
    end
`endif
  end

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      stateQ <= StIdle;
      roundQ <= '0;
      keyQ   <= '0;
      tweakQ <= '0;
    end else begin
      stateQ <= stateD;
      roundQ <= roundD;
      if (startAccept) begin
        keyQ[7:0]   <= inKey;
        keyQ[8]     <= keyParity;
        tweakQ[1:0] <= inTweak;
        tweakQ[2]   <= inTweak[63:0] ^ inTweak[127:64];
      end
    end
  end

endmodule

// File: tb/tb_round_engine.sv
// tb_round_engine: randomized self-checking bench for round_engine against a
// word-level Threefish-512 reference model. Cycle numbering: the cycle in which
// the start edge occurs is cycle 1, so outDone is expected in cycle 74.
module tb_round_engine;

  localparam logic [63:0] RefC240 = 64'h1BD1_1BDA_A9FC_1A22;
  localparam int RefRot [8][4] = '{
    '{46, 36, 19, 37}, '{33, 27, 14, 42}, '{17, 49, 36, 39}, '{44, 9, 54, 56},
    '{39, 30, 34, 24}, '{13, 50, 10, 17}, '{25, 29, 39, 43}, '{8, 35, 56, 22}
  };
  localparam int RefPi [8] = '{2, 1, 4, 7, 6, 5, 0, 3};

  logic         inClk = 1'b0;
  logic         inRstN = 1'b0;
  logic         inStart = 1'b0;
`ifdef ROUNDENG_ABORT_EN
  logic         inAbort = 1'b0;
`endif
  logic [511:0] inKey = '0;
  logic [127:0] inTweak = '0;
  logic [511:0] inState;
  logic         outWr;
  logic [511:0] outBlock;
  logic         outBusy;
  logic         outDone;

  // Behavioural round register with an external load port.
  logic [511:0] regQ;
  logic         loadEn = 1'b0;
  logic [511:0] loadVal = '0;

  int nVectors = 0;
  int nMiscompares = 0;

  round_engine dut (
    .inClk    (inClk),
    .inRstN   (inRstN),
    .inStart  (inStart),
`ifdef ROUNDENG_ABORT_EN
    .inAbort  (inAbort),
`endif
    .inKey    (inKey),
    .inTweak  (inTweak),
    .inState  (inState),
    .outWr    (outWr),
    .outBlock (outBlock),
    .outBusy  (outBusy),
    .outDone  (outDone)
  );

  always #5 inClk = ~inClk;

  always @(posedge inClk) begin
    if (loadEn) regQ <= loadVal;
    else if (outWr) regQ <= outBlock;
  end
  assign inState = regQ;

  task automatic checkVal(input string tag, input logic [511:0] got, input logic [511:0] exp);
    nVectors++;
    if (got !== exp) begin
      nMiscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rotl(input logic [63:0] x, input int r);
    return (x << r) | (x >> (64 - r));
  endfunction

  // Threefish-512 after nRounds rounds; nRounds == 72 includes the final subkey.
  function automatic logic [511:0] tfModel(input logic [511:0] key, input logic [127:0] tw,
                                           input logic [511:0] pt, input int nRounds);
    logic [63:0] k [9];
    logic [63:0] t [3];
    logic [63:0] v [8];
    logic [63:0] f [8];
    logic [511:0] res;
    int s;
    k[8] = RefC240;
    for (int i = 0; i < 8; i++) begin
      k[i] = key[64*i +: 64];
      k[8] = k[8] ^ k[i];
      v[i] = pt[64*i +: 64];
    end
    t[0] = tw[63:0];
    t[1] = tw[127:64];
    t[2] = t[0] ^ t[1];
    for (int d = 0; d <= nRounds; d++) begin
      if (d % 4 == 0 && (d < nRounds || d == 72)) begin
        s = d / 4;
        for (int i = 0; i < 8; i++) v[i] = v[i] + k[(s + i) % 9];
        v[5] = v[5] + t[s % 3];
        v[6] = v[6] + t[(s + 1) % 3];
        v[7] = v[7] + 64'(s);
      end
      if (d == nRounds) break;
      for (int j = 0; j < 4; j++) begin
        f[2*j]   = v[2*j] + v[2*j+1];
        f[2*j+1] = rotl(v[2*j+1], RefRot[d % 8][j]) ^ f[2*j];
      end
      for (int i = 0; i < 8; i++) v[i] = f[RefPi[i]];
    end
    for (int i = 0; i < 8; i++) res[64*i +: 64] = v[i];
    return res;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Loads the plaintext, then raises inStart; the next negedge is cycle 1.
  task automatic startOp(input logic [511:0] key, input logic [127:0] tw, input logic [511:0] pt);
    @(negedge inClk);
    loadEn  = 1'b1;
    loadVal = pt;
    inKey   = key;
    inTweak = tw;
    @(negedge inClk);
    loadEn  = 1'b0;
    inStart = 1'b1;
  endtask

  task automatic runOp(input string tag, input logic [511:0] key, input logic [127:0] tw,
                       input logic [511:0] pt, input bit toggle, input bit checkMid);
    int wrCount = 0;
    int doneAt = 0;
    logic [511:0] r;
    startOp(key, tw, pt);
    for (int k = 1; k <= 100; k++) begin
      @(negedge inClk);
      if (k == 1) begin
        inStart = 1'b0;
        checkVal({tag, " busy"}, 512'(outBusy), 512'd1);
      end
      if (checkMid && k == 5) checkVal({tag, " round3"}, regQ, tfModel(key, tw, pt, 4));
      if (outWr) wrCount++;
      if (outDone) begin
        doneAt = k;
        break;
      end
      if (toggle) begin
        r = rand512();
        inKey   = r;
        inTweak = r[511:384];
      end
    end
    checkVal({tag, " wrCount"}, 512'(wrCount), 512'd73);
    checkVal({tag, " doneCycle"}, 512'(doneAt), 512'd74);
    checkVal({tag, " cipher"}, regQ, tfModel(key, tw, pt, 72));
    @(negedge inClk);
    checkVal({tag, " idle"}, {outDone, outBusy, outWr}, 512'd0);
  endtask

  initial begin
    logic [511:0] key, pt, r;
    logic [127:0] tw;
    int doneCnt, wrCnt, firstDone, secondDone;

    #12;
    checkVal("reset outputs", {outWr, outBusy, outDone}, 512'd0);
    checkVal("reset block", outBlock, 512'd0);
    @(negedge inClk);
    inRstN = 1'b1;
    @(negedge inClk);
    checkVal("idle block zero", outBlock, 512'd0);

    runOp("zero", '0, '0, '0, 1'b0, 1'b1);

    for (int b = 0; b < 64; b++) begin
      key[8*b +: 8] = 8'(b);
      pt[8*b +: 8]  = 8'(8'hFF - b);
    end
    for (int b = 0; b < 16; b++) tw[8*b +: 8] = 8'(8'h0F - b);
    runOp("ramp", key, tw, pt, 1'b0, 1'b1);
    runOp("ramp toggled", key, tw, pt, 1'b1, 1'b0);

    // inStart held high for 200 cycles.
    doneCnt = 0; wrCnt = 0; firstDone = 0; secondDone = 0;
    startOp(key, tw, pt);
    for (int k = 1; k <= 200; k++) begin
      @(negedge inClk);
      if (outWr) wrCnt++;
      if (outDone) begin
        doneCnt++;
        if (doneCnt == 1) firstDone = k;
        if (doneCnt == 2) secondDone = k;
      end
    end
    inStart = 1'b0;
    checkVal("held doneCount", 512'(doneCnt), 512'd2);
    checkVal("held firstDone", 512'(firstDone), 512'd74);
    checkVal("held secondDone", 512'(secondDone), 512'd149);
    doneCnt = 0;
    for (int k = 0; k < 150 && doneCnt == 0; k++) begin
      @(negedge inClk);
      if (outDone) doneCnt = 1;
    end
    checkVal("held thirdDone seen", 512'(doneCnt), 512'd1);
    checkVal("held cipher x3", regQ,
             tfModel(key, tw, tfModel(key, tw, tfModel(key, tw, pt, 72), 72), 72));

    // Asynchronous reset at round 40.
    startOp(key, tw, pt);
    for (int k = 1; k <= 41; k++) begin
      @(negedge inClk);
      if (k == 1) inStart = 1'b0;
    end
    checkVal("pre-reset busy", {outBusy, outWr}, 512'd3);
    inRstN = 1'b0;
    #1;
    checkVal("async reset drop", {outWr, outBusy, outDone}, 512'd0);
    checkVal("async reset block", outBlock, 512'd0);
    @(negedge inClk);
    inRstN = 1'b1;
    runOp("after reset", key, tw, pt, 1'b0, 1'b0);

`ifdef ROUNDENG_ABORT_EN
    startOp(key, tw, pt);
    for (int k = 1; k <= 11; k++) begin
      @(negedge inClk);
      if (k == 1) inStart = 1'b0;
    end
    inAbort = 1'b1;
    #1;
    checkVal("abort no write", 512'(outWr), 512'd0);
    @(negedge inClk);
    inAbort = 1'b0;
    checkVal("abort idle", {outBusy, outWr}, 512'd0);
    checkVal("abort state", regQ, tfModel(key, tw, pt, 10));
    doneCnt = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge inClk);
      if (outDone || outBusy) doneCnt++;
    end
    checkVal("abort no done", 512'(doneCnt), 512'd0);
    runOp("after abort", key, tw, pt, 1'b0, 1'b0);
`endif

    for (int n = 0; n < 4; n++) begin
      key = rand512();
      pt  = rand512();
      r   = rand512();
      tw  = r[127:0];
      runOp($sformatf("rand%0d", n), key, tw, pt, n[0], n == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
